// File: rtl/ti_sbox_seq_pkg.sv
// Shared definitions for the masked S-box sequencer: FSM encoding, PRNG seed
// and xorshift shift amounts, plus a byte-lane helper (byte 0 = MS byte).
package ti_sbox_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [127:0] SEED_DEF = 128'h0123456789ABCDEFFEDCBA9876543210;

  localparam int unsigned XS_A = 11;
  localparam int unsigned XS_B = 19;
  localparam int unsigned XS_C = 8;

  function automatic logic [7:0] byte_of(logic [127:0] v, logic [3:0] i);
    return v[8*(15-int'(i)) +: 8];
  endfunction

endpackage

// File: rtl/xorshift128.sv
// Free-running xorshift128 mask generator; state {x,y,z,w}, x in the MS word.
module xorshift128
  import ti_sbox_seq_pkg::*;
#(
  parameter logic [127:0] SEED = SEED_DEF
) (
  input  logic        CLK,
  input  logic        RSTn,
  output logic [31:0] rnd
);

  logic [31:0] x, y, z, w, t;

  assign t = x ^ (x << XS_A);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      {x, y, z, w} <= SEED;
    end else begin
      x <= y;
      y <= z;
      z <= w;
      w <= w ^ (w >> XS_B) ^ t ^ (t >> XS_C);
    end
  end

  assign rnd = w;

endmodule

// File: rtl/ti_sbox_seq.sv
// Sequences a 2-share 128-bit state byte-by-byte through an external masked
// S-box pipeline of fixed latency LAT and reassembles the result shares.
module ti_sbox_seq
  import ti_sbox_seq_pkg::*;
#(
  parameter int           LAT  = 3,
  parameter logic [127:0] SEED = SEED_DEF
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         start,
  input  logic [127:0] din0,
  input  logic [127:0] din1,
  output logic         busy,
  output logic         done,
  output logic [127:0] dout0,
  output logic [127:0] dout1,
  output logic         sb_ivld,
  output logic [7:0]   sb_in0,
  output logic [7:0]   sb_in1,
  output logic [31:0]  rnd,
  input  logic         sb_ovld,
  input  logic [7:0]   sb_out0,
  input  logic [7:0]   sb_out1
);

  if (LAT < 1 || LAT > 8) begin : g_lat_chk
    $error("ti_sbox_seq: LAT must be 1..8");
  end
  if (SEED == 128'd0) begin : g_seed_chk
    $error("ti_sbox_seq: SEED must be nonzero");
  end

  state_t       st, st_nx;
  logic [127:0] sh0, sh1, col0, col1;
  logic [3:0]   ic, cc;
  logic         acc_start, take, last_res;

  assign acc_start = (st == S_IDLE) && start;
  assign take      = sb_ovld && (st == S_FEED || st == S_DRAIN);
  assign last_res  = take && (cc == 4'd15);

  xorshift128 #(.SEED(SEED)) u_prng (
    .CLK  (CLK),
    .RSTn (RSTn),
    .rnd  (rnd)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) st <= S_IDLE;
    else       st <= st_nx;
  end

  // Results may complete while still issuing (short LAT), so FEED can exit to DONE.
  always_comb begin
    st_nx = st;
    unique case (st)
      S_IDLE:  if (start) st_nx = S_FEED;
      S_FEED:  if (last_res) st_nx = S_DONE;
               else if (ic == 4'd15) st_nx = S_DRAIN;
      S_DRAIN: if (last_res) st_nx = S_DONE;
      S_DONE:  st_nx = S_IDLE;
      default: st_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (st == S_FEED) || (st == S_DRAIN);
    done = (st == S_DONE);
  end

  // Issue side: byte 0 goes out straight from din so it lands the cycle after start.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sh0     <= '0;
      sh1     <= '0;
      ic      <= '0;
      sb_ivld <= 1'b0;
      sb_in0  <= '0;
      sb_in1  <= '0;
    end else if (acc_start) begin
      sh0     <= din0;
      sh1     <= din1;
      ic      <= '0;
      sb_ivld <= 1'b1;
      sb_in0  <= byte_of(din0, 4'd0);
      sb_in1  <= byte_of(din1, 4'd0);
    end else if (st == S_FEED) begin
      ic      <= ic + 4'd1;
      sb_ivld <= (ic != 4'd15);
      sb_in0  <= byte_of(sh0, ic + 4'd1);
      sb_in1  <= byte_of(sh1, ic + 4'd1);
    end else begin
      sb_ivld <= 1'b0;
    end
  end

  // Collect side: last byte bypasses the collect regs straight into dout.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      col0  <= '0;
      col1  <= '0;
      cc    <= '0;
      dout0 <= '0;
      dout1 <= '0;
    end else begin
      if (acc_start) begin
        cc <= '0;
      end else if (take) begin
        col0[8*(15-int'(cc)) +: 8] <= sb_out0;
        col1[8*(15-int'(cc)) +: 8] <= sb_out1;
        cc <= cc + 4'd1;
      end
      if (last_res) begin
        dout0 <= {col0[127:8], sb_out0};
        dout1 <= {col1[127:8], sb_out1};
      end
    end
  end

endmodule
